// File: rtl/si_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : si_cmd_decoder
//  Description : Turns a stream of two-byte frames (address byte, then data
//                byte) into single writes on the Simple Interface register
//                bus. Drops a frame whose data byte arrives too late and a
//                write whose acknowledge never comes, flagging each case
//                with a one-cycle error pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RX_TIMEOUT     max clk cycles between address byte and data byte
//    ACK_TIMEOUT    max clk cycles register_rdy is held without register_ack
//  Ports
//    clk            system clock, rising edge
//    rst            synchronous reset, active low
//    rx_data[7:0]   byte from the upstream source
//    rx_rdy         rx_data valid
//    rx_ack         byte accept (combinational, low only while writing)
//    register_addr  register bus address
//    register_data  register bus write data
//    register_rdy   register bus write request (registered)
//    register_ack   register bus acknowledge
//    err_rx_timeout pulse: frame dropped, data byte missing
//    err_nack       pulse: write dropped, no acknowledge
//    write_count    acknowledged writes, modulo 256
// ============================================================================
module si_cmd_decoder #(
    parameter int unsigned RX_TIMEOUT  = 1000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_ack,
    output logic [7:0] register_addr,
    output logic [7:0] register_data,
    output logic       register_rdy,
    input  logic       register_ack,
    output logic       err_rx_timeout,
    output logic       err_nack,
    output logic [7:0] write_count
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_DATA = 2'd1;
    localparam logic [1:0] c_WRITE     = 2'd2;

    // Terminal counts; timeouts are limited to 65535 so 16 bits suffice.
    localparam logic [15:0] c_RX_LAST  = 16'(RX_TIMEOUT - 1);
    localparam logic [15:0] c_ACK_LAST = 16'(ACK_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [15:0] r_count;
    logic [7:0]  r_addr;
    logic [7:0]  r_data;
    logic        r_rdy;
    logic        r_err_rx;
    logic        r_err_nack;
    logic [7:0]  r_write_count;

    logic        w_xfer;
    logic        w_count_clr;
    logic        w_count_inc;
    logic        w_latch_addr;
    logic        w_latch_data;
    logic        w_set_err_rx;
    logic        w_set_err_nack;
    logic        w_write_done;

    // Source may hand over a byte whenever we are not busy on the register bus.
    assign rx_ack = (r_state != c_WRITE);
    assign w_xfer = rx_rdy & rx_ack;

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_count_clr    = 1'b0;
        w_count_inc    = 1'b0;
        w_latch_addr   = 1'b0;
        w_latch_data   = 1'b0;
        w_set_err_rx   = 1'b0;
        w_set_err_nack = 1'b0;
        w_write_done   = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (w_xfer) begin
                    w_latch_addr = 1'b1;
                    w_count_clr  = 1'b1;
                    w_next_state = c_WAIT_DATA;
                end
            end

            c_WAIT_DATA: begin
                // A byte arriving on the expiry edge still wins.
                if (w_xfer) begin
                    w_latch_data = 1'b1;
                    w_count_clr  = 1'b1;
                    w_next_state = c_WRITE;
                end else if (r_count == c_RX_LAST) begin
                    w_set_err_rx = 1'b1;
                    w_count_clr  = 1'b1;
                    w_next_state = c_IDLE;
                end else begin
                    w_count_inc  = 1'b1;
                end
            end

            c_WRITE: begin
                // An acknowledge on the expiry edge still completes the write.
                if (register_ack) begin
                    w_write_done = 1'b1;
                    w_count_clr  = 1'b1;
                    w_next_state = c_IDLE;
                end else if (r_count == c_ACK_LAST) begin
                    w_set_err_nack = 1'b1;
                    w_count_clr    = 1'b1;
                    w_next_state   = c_IDLE;
                end else begin
                    w_count_inc    = 1'b1;
                end
            end

            default: begin
                w_count_clr  = 1'b1;
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, datapath and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_count       <= 16'd0;
            r_addr        <= 8'd0;
            r_data        <= 8'd0;
            r_rdy         <= 1'b0;
            r_err_rx      <= 1'b0;
            r_err_nack    <= 1'b0;
            r_write_count <= 8'd0;
        end else begin
            r_state <= w_next_state;

            if (w_count_clr) begin
                r_count <= 16'd0;
            end else if (w_count_inc) begin
                r_count <= r_count + 16'd1;
            end

            // Address/data only load outside WRITE, so they hold for the
            // whole register-bus transaction.
            if (w_latch_addr) begin
                r_addr <= rx_data;
            end
            if (w_latch_data) begin
                r_data <= rx_data;
            end

            // Registered copy of "state is WRITE" so the request is glitch free.
            r_rdy      <= (w_next_state == c_WRITE);
            r_err_rx   <= w_set_err_rx;
            r_err_nack <= w_set_err_nack;

            if (w_write_done) begin
                r_write_count <= r_write_count + 8'd1;
            end
        end
    end

    assign register_addr  = r_addr;
    assign register_data  = r_data;
    assign register_rdy   = r_rdy;
    assign err_rx_timeout = r_err_rx;
    assign err_nack       = r_err_nack;
    assign write_count    = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_si_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_si_cmd_decoder
//  Description : Self-checking bench for si_cmd_decoder. Expected writes are
//                queued as {addr,data} when frames are driven and popped when
//                the decoder presents them on the register bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_si_cmd_decoder;

    localparam int RX  = 8;
    localparam int ACK = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_rdy = 1'b0;
    logic       rx_ack;
    logic [7:0] register_addr;
    logic [7:0] register_data;
    logic       register_rdy;
    logic       register_ack = 1'b0;
    logic       err_rx_timeout;
    logic       err_nack;
    logic [7:0] write_count;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb_q[$];
    logic [7:0]  exp_wc = 8'd0;

    si_cmd_decoder #(
        .RX_TIMEOUT (RX),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_rdy        (rx_rdy),
        .rx_ack        (rx_ack),
        .register_addr (register_addr),
        .register_data (register_data),
        .register_rdy  (register_rdy),
        .register_ack  (register_ack),
        .err_rx_timeout(err_rx_timeout),
        .err_nack      (err_nack),
        .write_count   (write_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until it is accepted on an edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        while (rx_ack !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (rx_ack !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_accept: rx_ack=%b required 1 after %0d cycles", rx_ack, n);
        end
        tick();
        rx_rdy = 1'b0;
    endtask

    // Full frame; register_ack is raised ack_at cycles after register_rdy rises.
    task automatic do_frame(input logic [7:0] a, input logic [7:0] d, input int ack_at,
                            output int rdy_cycles, output logic err_seen);
        logic [15:0] exp;
        send_byte(a);
        sb_q.push_back({a, d});
        send_byte(d);
        rdy_cycles = 0;
        err_seen   = 1'b0;
        for (int i = 0; i <= ack_at; i++) begin
            if (register_rdy === 1'b1) rdy_cycles++;
            err_seen = err_seen | err_rx_timeout | err_nack;
            if (i == 0) begin
                checks++;
                if (register_rdy !== 1'b1 || rx_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_write_entry: rdy=%b rx_ack=%b required 1/0", register_rdy, rx_ack);
                end
            end
            if (i == ack_at) begin
                register_ack = 1'b1;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
                checks++;
                if ({register_addr, register_data} !== exp) begin
                    errors++;
                    $display("FAIL frame_addr_data: got %h/%h required %h/%h",
                             register_addr, register_data, exp[15:8], exp[7:0]);
                end
            end
            tick();
        end
        register_ack = 1'b0;
        exp_wc = exp_wc + 8'd1;
        err_seen = err_seen | err_rx_timeout | err_nack;
        checks++;
        if (register_rdy !== 1'b0 || write_count !== exp_wc) begin
            errors++;
            $display("FAIL frame_complete: rdy=%b write_count=%0d required 0/%0d",
                     register_rdy, write_count, exp_wc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (register_addr !== 8'd0 || register_data !== 8'd0 || register_rdy !== 1'b0 ||
            err_rx_timeout !== 1'b0 || err_nack !== 1'b0 || write_count !== 8'd0 || rx_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: addr=%h data=%h rdy=%b erx=%b enack=%b wc=%0d rx_ack=%b required 0,0,0,0,0,0,1",
                     register_addr, register_data, register_rdy, err_rx_timeout, err_nack, write_count, rx_ack);
        end
        rst = 1'b1;
        exp_wc = 8'd0;
        tick();
    endtask

    task automatic test_basic_write;
        int   rc;
        logic es;
        do_frame(8'h03, 8'h5A, 2, rc, es);
        checks++;
        if (rc != 3 || es !== 1'b0 || write_count !== 8'd1) begin
            errors++;
            $display("FAIL basic_write: rdy_cycles=%0d err=%b wc=%0d required 3/0/1", rc, es, write_count);
        end
    endtask

    task automatic test_rx_timeout;
        int   pulses;
        int   rc;
        logic es;
        pulses = 0;
        send_byte(8'h10);
        for (int i = 1; i <= RX + 2; i++) begin
            tick();
            if (err_rx_timeout === 1'b1) pulses++;
            if (i == RX) begin
                checks++;
                if (err_rx_timeout !== 1'b1 || err_nack !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_timeout_pulse: erx=%b enack=%b required 1/0", err_rx_timeout, err_nack);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL rx_timeout_count: pulses=%0d required 1", pulses);
        end
        do_frame(8'h01, 8'h22, 0, rc, es);
        checks++;
        if (es !== 1'b0 || rc != 1) begin
            errors++;
            $display("FAIL rx_timeout_recover: err=%b rdy_cycles=%0d required 0/1", es, rc);
        end
    endtask

    task automatic test_nack;
        int rc;
        int pulses;
        rc = 0;
        pulses = 0;
        send_byte(8'hFF);
        send_byte(8'h11);
        for (int i = 0; i <= ACK + 1; i++) begin
            if (register_rdy === 1'b1) begin
                rc++;
                checks++;
                if (register_addr !== 8'hFF || register_data !== 8'h11) begin
                    errors++;
                    $display("FAIL nack_hold: got %h/%h required ff/11", register_addr, register_data);
                end
            end
            if (err_nack === 1'b1) pulses++;
            if (i == ACK) begin
                checks++;
                if (err_nack !== 1'b1 || err_rx_timeout !== 1'b0 || register_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL nack_pulse: enack=%b erx=%b rdy=%b required 1/0/0", err_nack, err_rx_timeout, register_rdy);
                end
            end
            tick();
        end
        checks++;
        if (rc != ACK || pulses != 1 || write_count !== exp_wc) begin
            errors++;
            $display("FAIL nack_summary: rdy_cycles=%0d pulses=%0d wc=%0d required %0d/1/%0d",
                     rc, pulses, write_count, ACK, exp_wc);
        end
    endtask

    task automatic test_coincident;
        int          rc;
        logic        es;
        logic [15:0] exp;
        // Ack on the very edge the ack timeout expires.
        do_frame(8'h33, 8'h44, ACK - 1, rc, es);
        tick();
        es = es | err_nack | err_rx_timeout;
        checks++;
        if (rc != ACK || es !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_timeout: rdy_cycles=%0d err=%b required %0d/0", rc, es, ACK);
        end
        // Data byte on the very edge the rx timeout expires.
        send_byte(8'h66);
        repeat (RX - 1) tick();
        sb_q.push_back({8'h66, 8'h77});
        send_byte(8'h77);
        checks++;
        if (register_rdy !== 1'b1 || register_data !== 8'h77 || err_rx_timeout !== 1'b0) begin
            errors++;
            $display("FAIL data_at_timeout: rdy=%b data=%h erx=%b required 1/77/0", register_rdy, register_data, err_rx_timeout);
        end
        register_ack = 1'b1;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        checks++;
        if ({register_addr, register_data} !== exp) begin
            errors++;
            $display("FAIL data_at_timeout_sb: got %h/%h required %h/%h",
                     register_addr, register_data, exp[15:8], exp[7:0]);
        end
        tick();
        register_ack = 1'b0;
        exp_wc = exp_wc + 8'd1;
        tick();
        checks++;
        if (write_count !== exp_wc || err_rx_timeout !== 1'b0 || err_nack !== 1'b0) begin
            errors++;
            $display("FAIL data_at_timeout_done: wc=%0d erx=%b enack=%b required %0d/0/0",
                     write_count, err_rx_timeout, err_nack, exp_wc);
        end
    endtask

    task automatic test_back_to_back;
        int          idx;
        int          done;
        int          cyc;
        logic        xfer;
        logic        acked;
        logic [15:0] exp;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_wc = 8'd0;
        sb_q.delete();
        idx = 0;
        done = 0;
        cyc = 0;
        while (done < 256 && cyc < 3000) begin
            acked = 1'b0;
            if (register_rdy === 1'b1) begin
                checks++;
                if (rx_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rx_ack_in_write: rx_ack=%b required 0", rx_ack);
                end
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
                checks++;
                if ({register_addr, register_data} !== exp) begin
                    errors++;
                    $display("FAIL b2b_addr_data: got %h/%h required %h/%h",
                             register_addr, register_data, exp[15:8], exp[7:0]);
                end
                register_ack = 1'b1;
                acked = 1'b1;
            end else begin
                register_ack = 1'b0;
            end
            if (err_rx_timeout !== 1'b0 || err_nack !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL b2b_error_pulse: erx=%b enack=%b required 0/0", err_rx_timeout, err_nack);
            end
            xfer = 1'b0;
            if (idx < 512) begin
                rx_rdy  = 1'b1;
                rx_data = (idx % 2 == 0) ? 8'(idx / 2) : (8'(idx / 2) ^ 8'hA5);
                xfer    = rx_ack;
                if (xfer && (idx % 2 == 1)) sb_q.push_back({8'(idx / 2), 8'(idx / 2) ^ 8'hA5});
            end else begin
                rx_rdy = 1'b0;
            end
            tick();
            cyc++;
            if (xfer) idx++;
            if (acked) begin
                done++;
                exp_wc = exp_wc + 8'd1;
                checks++;
                if (write_count !== exp_wc) begin
                    errors++;
                    $display("FAIL b2b_write_count: wc=%0d required %0d", write_count, exp_wc);
                end
            end
        end
        register_ack = 1'b0;
        rx_rdy = 1'b0;
        checks++;
        if (done != 256 || write_count !== 8'd0 || idx != 512) begin
            errors++;
            $display("FAIL b2b_wrap: writes=%0d wc=%0d bytes=%0d required 256/0/512", done, write_count, idx);
        end
    endtask

    task automatic test_reset_in_write;
        int   rc;
        logic es;
        int   pulses;
        send_byte(8'h77);
        send_byte(8'h88);
        checks++;
        if (register_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rst_write_entry: rdy=%b required 1", register_rdy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (register_addr !== 8'd0 || register_data !== 8'd0 || register_rdy !== 1'b0 ||
            err_rx_timeout !== 1'b0 || err_nack !== 1'b0 || write_count !== 8'd0 || rx_ack !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_write: addr=%h data=%h rdy=%b erx=%b enack=%b wc=%0d rx_ack=%b required 0,0,0,0,0,0,1",
                     register_addr, register_data, register_rdy, err_rx_timeout, err_nack, write_count, rx_ack);
        end
        rst = 1'b1;
        exp_wc = 8'd0;
        sb_q.delete();
        // Reset while waiting for data: frame aborted silently.
        send_byte(8'h99);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pulses = 0;
        repeat (RX + 3) begin
            tick();
            if (err_rx_timeout === 1'b1 || err_nack === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || register_addr !== 8'd0) begin
            errors++;
            $display("FAIL rst_in_wait: pulses=%0d addr=%h required 0/00", pulses, register_addr);
        end
        do_frame(8'h21, 8'h43, 1, rc, es);
        checks++;
        if (rc != 2 || es !== 1'b0 || write_count !== 8'd1) begin
            errors++;
            $display("FAIL rst_recover: rdy_cycles=%0d err=%b wc=%0d required 2/0/1", rc, es, write_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_rx_timeout();
        test_nack();
        test_coincident();
        test_back_to_back();
        test_reset_in_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
